// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite byte-addressable SRAM slave with wait states and ERROR response
// OKAY data phase lasts 1+WAIT_STATES cycles; ERROR is always two cycles; writes commit on the edge ending the data phase.
module ahb_sram_slave #(
   parameter int MEM_BYTES   = 1024,
   parameter int AW          = $clog2(MEM_BYTES),
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready_in,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      wcnt_q, wcnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            write_q, write_d;
   logic [1:0]      size_q, size_d;

   logic [7:0]      mem_q [MEM_BYTES];

   logic            accept;
   logic            illegal;
   logic [3:0]      lanes;
   logic            wr_en;
   logic            rd_en;
   logic            unused_htrans;

   assign unused_htrans = htrans[0];

   function automatic logic [7:0] reset_byte(input int idx);
      case (idx)
         0:       reset_byte = 8'hAA;
         1:       reset_byte = 8'hBB;
         2:       reset_byte = 8'hCC;
         3:       reset_byte = 8'hDD;
         4:       reset_byte = 8'hEE;
         default: reset_byte = 8'h00;
      endcase
   endfunction

   assign accept  = hsel && htrans[1] && hready_in;
   assign illegal = (hsize > 3'b010)
                 || ((hsize == 3'b001) && haddr[0])
                 || ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
                 || (haddr[31:AW] != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         wcnt_q  <= 3'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      case (state_q)
         ST_WAIT: begin
            wcnt_d = wcnt_q - 3'd1;
            if (wcnt_q == 3'd1) begin
               state_d = ST_DATA;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            // IDLE, DATA and ERR2 all present hreadyout=1, so a new address phase may land here
            state_d = ST_IDLE;
            wcnt_d  = 3'd0;
            if (accept) begin
               addr_d  = haddr[AW-1:0];
               write_d = hwrite;
               size_d  = hsize[1:0];
               if (illegal) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES == 0) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_WAIT;
                  wcnt_d  = 3'(WAIT_STATES);
               end
            end
         end
      endcase
   end

   assign hreadyout = (state_q != ST_WAIT) && (state_q != ST_ERR1);
   assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

   always_comb begin
      lanes = 4'b0000;
      case (size_q)
         2'b00:   lanes[addr_q[1:0]] = 1'b1;
         2'b01:   lanes = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
   end

   assign wr_en = (state_q == ST_DATA) && write_q;
   assign rd_en = (state_q == ST_DATA) && !write_q;

   // The array resets asynchronously so an abandoned write never lands
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MEM_BYTES; i++) begin
            mem_q[AW'(i)] <= reset_byte(i);
         end
      end else if (wr_en) begin
         for (int n = 0; n < 4; n++) begin
            if (lanes[n[1:0]]) begin
               mem_q[{addr_q[AW-1:2], n[1:0]}] <= hwdata[8*n +: 8];
            end
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_rd_lane
      assign hrdata[8*g +: 8] = (rd_en && lanes[g]) ? mem_q[{addr_q[AW-1:2], 2'(g)}] : 8'h00;
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized bench for ahb_sram_slave against a byte-array bus model
// Two slaves (0 wait states / 1024 B, 3 wait states / 256 B) share one AHB-Lite bus.
module tb_ahb_sram_slave;

   typedef struct {
      bit          dut;
      bit          sel;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hsel0, hsel1;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hro0, hro1, hresp0, hresp1;
   logic [31:0] hrdata0, hrdata1;
   logic        hready;
   logic        hresp_bus;
   logic [31:0] hrdata_bus;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  mem [2][1024];
   xfer_t       q[$];

   assign hready     = hro0 & hro1;
   assign hresp_bus  = hresp0 | hresp1;
   assign hrdata_bus = hrdata0 | hrdata1;

   always #5 clk = ~clk;

   ahb_sram_slave #(.MEM_BYTES(1024), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready),
      .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0)
   );

   ahb_sram_slave #(.MEM_BYTES(256), .WAIT_STATES(3)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready),
      .hreadyout(hro1), .hresp(hresp1), .hrdata(hrdata1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int msz(input bit d);
      return d ? 256 : 1024;
   endfunction

   function automatic bit illegal(input xfer_t x);
      return (x.size > 3'd2) || (x.size == 3'd1 && x.addr % 2 != 0)
          || (x.size == 3'd2 && x.addr % 4 != 0) || (x.addr >= 32'(msz(x.dut)));
   endfunction

   function automatic bit lane_on(input xfer_t x, input int i);
      case (x.size)
         3'd0:    return i == int'(x.addr % 4);
         3'd1:    return i / 2 == int'((x.addr / 2) % 2);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input xfer_t x);
      logic [31:0] r = 32'h0;
      int base = int'(x.addr / 4) * 4;
      for (int i = 0; i < 4; i++) begin
         if (lane_on(x, i)) r[8*i +: 8] = mem[x.dut][base + i];
      end
      return r;
   endfunction

   task automatic model_write(input xfer_t x);
      int base = int'(x.addr / 4) * 4;
      for (int i = 0; i < 4; i++) begin
         if (lane_on(x, i)) mem[x.dut][base + i] = x.wdata[8*i +: 8];
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 1024; i++) mem[d][i] = 8'h00;
         mem[d][0] = 8'hAA; mem[d][1] = 8'hBB; mem[d][2] = 8'hCC;
         mem[d][3] = 8'hDD; mem[d][4] = 8'hEE;
      end
   endtask

   task automatic drive_idle();
      hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00;
      haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
   endtask

   function automatic xfer_t mk(input bit d, input logic w, input logic [2:0] s,
                                input logic [31:0] a, input logic [31:0] wd);
      xfer_t x;
      x.dut = d; x.sel = 1'b1; x.trans = 2'b10; x.write = w;
      x.size = s; x.addr = a; x.wdata = wd;
      return x;
   endfunction

   // Pipelined master: issues q back-to-back, checks every cycle against the model
   task automatic run_q();
      xfer_t       a, d;
      bit          a_v = 0, d_v = 0, err = 0, exp_rdy;
      int          cnt = 0, cyc = 0, ws;
      logic [31:0] exp_rd;
      @(posedge clk); #1;
      if (q.size() > 0) begin a = q.pop_front(); a_v = 1; end
      while ((a_v || d_v) && cyc < 20000) begin
         cyc++;
         if (a_v) begin
            hsel0 = a.sel && !a.dut; hsel1 = a.sel && a.dut;
            haddr = a.addr; htrans = a.trans; hwrite = a.write; hsize = a.size;
         end else begin
            drive_idle();
         end
         hwdata = d_v ? d.wdata : $urandom();
         @(negedge clk);
         if (d_v) begin
            err     = illegal(d);
            ws      = d.dut ? 3 : 0;
            exp_rdy = err ? (cnt == 1) : (cnt == ws);
            exp_rd  = (!err && !d.write && exp_rdy) ? model_read(d) : 32'h0;
            check($sformatf("hreadyout s%0d @%0h c%0d", d.dut, d.addr, cnt), 32'(hready), 32'(exp_rdy));
            check($sformatf("hresp s%0d @%0h c%0d", d.dut, d.addr, cnt), 32'(hresp_bus), 32'(err));
            check($sformatf("hrdata s%0d @%0h sz%0d", d.dut, d.addr, d.size), hrdata_bus, exp_rd);
         end else begin
            err     = 0;
            exp_rdy = 1;
            check("idle hreadyout", 32'(hready), 32'h1);
            check("idle hresp", 32'(hresp_bus), 32'h0);
            check("idle hrdata", hrdata_bus, 32'h0);
         end
         @(posedge clk);
         if (exp_rdy) begin
            if (d_v && !err && d.write) model_write(d);
            d_v = 0;
            if (a_v && a.sel && a.trans[1]) begin d = a; d_v = 1; cnt = 0; end
            a_v = 0;
            if (q.size() > 0) begin a = q.pop_front(); a_v = 1; end
         end else begin
            cnt++;
         end
         #1;
      end
      if (cyc >= 20000) check("run_q cycle budget", 32'(cyc), 32'd19999);
      drive_idle();
   endtask

   function automatic xfer_t rand_xfer();
      xfer_t x;
      int    r, m;
      x.dut   = 1'($urandom_range(0, 1));
      x.sel   = ($urandom_range(0, 9) != 0);
      r       = $urandom_range(0, 9);
      x.trans = (r < 6) ? 2'b10 : (r < 8) ? 2'b11 : (r < 9) ? 2'b00 : 2'b01;
      x.write = 1'($urandom_range(0, 1));
      r       = $urandom_range(0, 15);
      x.size  = (r < 14) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      x.wdata = $urandom();
      m       = msz(x.dut);
      x.addr  = $urandom_range(0, 47);
      if (x.size < 3 && $urandom_range(0, 6) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 1);
      if ($urandom_range(0, 15) == 0) begin
         x.addr = $urandom_range(0, 1) ? 32'(m) + 32'($urandom_range(0, m - 1)) : (32'h8000_0000 | x.addr);
      end
      return x;
   endfunction

   initial begin
      drive_idle();
      hwdata = 32'h0;
      model_reset();
      #12;
      check("reset hreadyout0", 32'(hro0), 32'h1);
      check("reset hreadyout1", 32'(hro1), 32'h1);
      check("reset hresp", 32'(hresp_bus), 32'h0);
      check("reset hrdata0", hrdata0, 32'h0);
      check("reset hrdata1", hrdata1, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      q.push_back(mk(0, 0, 3'd2, 32'h000, 32'h0));
      run_q();

      q.push_back(mk(0, 1, 3'd0, 32'h006, 32'h005A_0000));
      q.push_back(mk(0, 1, 3'd1, 32'h00A, 32'h1234_0000));
      q.push_back(mk(0, 0, 3'd2, 32'h004, 32'h0));
      q.push_back(mk(0, 0, 3'd2, 32'h008, 32'h0));
      run_q();

      q.push_back(mk(0, 1, 3'd2, 32'h010, 32'hCAFE_F00D));
      q.push_back(mk(0, 0, 3'd2, 32'h010, 32'h0));
      run_q();

      q.push_back(mk(0, 0, 3'd2, 32'h002, 32'h0));
      q.push_back(mk(0, 1, 3'd2, 32'd1024, 32'h1111_2222));
      q.push_back(mk(1, 1, 3'd2, 32'd256, 32'h3333_4444));
      q.push_back(mk(0, 0, 3'd2, 32'h000, 32'h0));
      q.push_back(mk(1, 0, 3'd2, 32'h000, 32'h0));
      run_q();

      q.push_back(mk(1, 1, 3'd2, 32'h020, 32'h8765_4321));
      q.push_back(mk(1, 0, 3'd2, 32'h020, 32'h0));
      q.push_back(mk(0, 0, 3'd1, 32'h012, 32'h0));
      run_q();

      @(posedge clk); #1;
      hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0;
      @(posedge clk); #1;
      drive_idle();
      hwdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("mid-write wait hreadyout1", 32'(hro1), 32'h0);
      #2 reset_n = 1'b0;
      #1;
      check("async reset hreadyout1", 32'(hro1), 32'h1);
      check("async reset hresp1", 32'(hresp1), 32'h0);
      check("async reset hrdata1", hrdata1, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      q.push_back(mk(1, 0, 3'd2, 32'h000, 32'h0));
      q.push_back(mk(0, 0, 3'd2, 32'h004, 32'h0));
      run_q();

      for (int blk = 0; blk < 8; blk++) begin
         for (int k = 0; k < 50; k++) q.push_back(rand_xfer());
         run_q();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
